// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep checker.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } sweep_state_t;

  localparam int DEFAULT_SETTLE_CYCLES = 1;

  // Truth-table width for an n-input gate.
  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tt_vector_counter.sv
// Vector index and settle counter for the sweep. The index walks 0..2**N_IN-1
// without wrapping; the settle counter measures how long a vector has been held.
module tt_vector_counter
  import tt_sweep_pkg::*;
#(
  parameter int N_IN          = 4,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            hold,
  input  logic            advance,
  output logic [N_IN-1:0] vec,
  output logic            settle_done,
  output logic            last_vec
);

  localparam int CW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

  logic [CW-1:0] settle_cnt;

  // Index and settle counters; clear restarts at vector 0, advance moves to the next vector.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; reset is synchronous, so it is only tested inside the clocked block.
    if (!rst_n) begin
      vec        <= '0;
      settle_cnt <= '0;
    end else if (clear) begin
      vec        <= '0;
      settle_cnt <= '0;
    end else if (advance) begin
      vec        <= vec + N_IN'(1);
      settle_cnt <= '0;
    end else if (hold && !settle_done) begin
      settle_cnt <= settle_cnt + CW'(1);
    end
  end

  assign settle_done = (settle_cnt == CW'(SETTLE_CYCLES));
  assign last_vec    = (vec == {N_IN{1'b1}});

endmodule

// File: rtl/tt_sweep_checker.sv
// Drives every input vector into a combinational gate, records the observed
// truth table and compares it against a table latched when the sweep starts.
module tt_sweep_checker
  import tt_sweep_pkg::*;
#(
  parameter  int N_IN          = 4,
  parameter  int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  localparam int TT_W          = tt_width(N_IN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [TT_W-1:0] expected_tt,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [TT_W-1:0] captured_tt,
  output logic [N_IN:0]   fail_count,
  output logic [N_IN-1:0] first_fail_idx
);

  sweep_state_t    state_q, state_d;
  logic [TT_W-1:0] expected_q;
  logic            cnt_clear, cnt_hold, cnt_advance, capture;
  logic            settle_done, last_vec;
  logic            accept, mismatch;

  tt_vector_counter #(
    .N_IN          (N_IN),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (cnt_clear),
    .hold        (cnt_hold),
    .advance     (cnt_advance),
    .vec         (dut_in),
    .settle_done (settle_done),
    .last_vec    (last_vec)
  );

  assign accept   = (state_q == ST_IDLE) && start && !abort;
  assign mismatch = (dut_out != expected_q[dut_in]);
  assign busy     = (state_q == ST_HOLD) || (state_q == ST_SAMPLE);
  assign done     = (state_q == ST_FINISH);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and counter control; abort takes priority over any sweep activity.
  always_comb begin
    // NOTE: every output of this block is given a default first so no path
    // through the case statement leaves a signal unassigned (which would infer a latch).
    state_d     = state_q;
    cnt_clear   = 1'b0;
    cnt_hold    = 1'b0;
    cnt_advance = 1'b0;
    capture     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_HOLD;
          cnt_clear = 1'b1;
        end
      end
      ST_HOLD: begin
        if (abort) begin
          state_d   = ST_IDLE;
          cnt_clear = 1'b1;
        end else begin
          cnt_hold = 1'b1;
          if (settle_done) state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          state_d   = ST_IDLE;
          cnt_clear = 1'b1;
        end else begin
          capture = 1'b1;
          if (last_vec) begin
            state_d   = ST_FINISH;
            cnt_clear = 1'b1;
          end else begin
            state_d     = ST_HOLD;
            cnt_advance = 1'b1;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Result datapath: latch the expected table on accept, accumulate results per sample.
  always_ff @(posedge clk) begin
    // NOTE: the captured table is an ordinary register, not a RAM, so it is
    // reset along with the rest of the results and reads as 0 out of reset.
    if (!rst_n) begin
      expected_q     <= '0;
      captured_tt    <= '0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      pass           <= 1'b0;
    end else if (accept) begin
      expected_q     <= expected_tt;
      captured_tt    <= '0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      pass           <= 1'b0;
    end else if (capture) begin
      captured_tt[dut_in] <= dut_out;
      if (mismatch) begin
        fail_count <= fail_count + (N_IN + 1)'(1);
        if (fail_count == '0) first_fail_idx <= dut_in;
      end
      // pass becomes valid on the same edge that enters FINISH.
      if (last_vec) pass <= (fail_count == '0) && !mismatch;
    end
  end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Randomized self-checking bench for tt_sweep_checker. Two instances: default
// settle time and SETTLE_CYCLES=0. The gate under test is a truth-table lookup.
module tb_tt_sweep_checker;

  localparam int N_IN   = 4;
  localparam int TT_W   = 16;
  localparam int CYC_S1 = TT_W * (1 + 2);
  localparam int CYC_S0 = TT_W * (0 + 2);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start, abort;
  logic [TT_W-1:0] expected_tt, gate_tt;
  logic [N_IN-1:0] dut_in;
  logic            dut_out, busy, done, pass;
  logic [TT_W-1:0] captured_tt;
  logic [N_IN:0]   fail_count;
  logic [N_IN-1:0] first_fail_idx;

  logic            start0, abort0;
  logic [TT_W-1:0] expected0, gate0_tt;
  logic [N_IN-1:0] dut_in0;
  logic            dut_out0, busy0, done0, pass0;
  logic [TT_W-1:0] captured0;
  logic [N_IN:0]   fail_count0;
  logic [N_IN-1:0] first_fail0;

  int tests_run = 0;
  int tests_failed = 0;
  int done_pulses = 0;

  always #5 clk = ~clk;

  assign dut_out  = gate_tt[dut_in];
  assign dut_out0 = gate0_tt[dut_in0];

  tt_sweep_checker #(.N_IN(N_IN), .SETTLE_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .expected_tt(expected_tt), .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .captured_tt(captured_tt),
    .fail_count(fail_count), .first_fail_idx(first_fail_idx)
  );

  tt_sweep_checker #(.N_IN(N_IN), .SETTLE_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .expected_tt(expected0), .dut_in(dut_in0), .dut_out(dut_out0),
    .busy(busy0), .done(done0), .pass(pass0), .captured_tt(captured0),
    .fail_count(fail_count0), .first_fail_idx(first_fail0)
  );

  always @(negedge clk) if (done === 1'b1) done_pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: result of comparing the first nvec vectors of gate g against table e.
  function automatic void model(input logic [TT_W-1:0] g, input logic [TT_W-1:0] e,
                                input int nvec, output logic [TT_W-1:0] cap,
                                output int fc, output int ffi);
    cap = '0; fc = 0; ffi = 0;
    for (int i = 0; i < nvec; i++) begin
      cap[i] = g[i];
      if (g[i] != e[i]) begin
        if (fc == 0) ffi = i;
        fc++;
      end
    end
  endfunction

  // One full sweep on the default instance; optionally pokes start while busy.
  task automatic run_sweep(input string tag, input logic [TT_W-1:0] g,
                           input logic [TT_W-1:0] e, input bit poke);
    logic [TT_W-1:0] cap;
    int fc, ffi, n, d0;
    model(g, e, TT_W, cap, fc, ffi);
    d0 = done_pulses;
    @(negedge clk);
    gate_tt = g; expected_tt = e; start = 1'b1;
    @(posedge clk);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      start = poke && ($urandom_range(3) == 0);
      expected_tt = TT_W'($urandom);
      if (done) break;
      @(posedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, ":cycles"}, n, CYC_S1);
    check({tag, ":done"}, done, 1'b1);
    check({tag, ":busy"}, busy, 1'b0);
    check({tag, ":dut_in"}, dut_in, '0);
    check({tag, ":pass"}, pass, (fc == 0));
    check({tag, ":captured"}, captured_tt, cap);
    check({tag, ":fail_count"}, fail_count, fc);
    check({tag, ":first_fail"}, first_fail_idx, ffi);
    @(negedge clk);
    check({tag, ":done_pulse"}, done, 1'b0);
    check({tag, ":pass_hold"}, pass, (fc == 0));
    repeat (3) @(negedge clk);
    check({tag, ":done_count"}, done_pulses - d0, 1);
  endtask

  // Wait (bounded) until the default instance drives vector v.
  task automatic wait_vec(input string tag, input logic [N_IN-1:0] v);
    int n = 0;
    while (dut_in !== v && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":reach_vec"}, dut_in, v);
  endtask

  initial begin
    logic [TT_W-1:0] g, e, cap;
    int fc, ffi, d0, n;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; expected_tt = '0; gate_tt = '0;
    start0 = 1'b0; abort0 = 1'b0; expected0 = '0; gate0_tt = '0;
    repeat (2) @(negedge clk);
    check("rst:busy", busy, 0);
    check("rst:done", done, 0);
    check("rst:pass", pass, 0);
    check("rst:captured", captured_tt, 0);
    check("rst:fail_count", fail_count, 0);
    check("rst:first_fail", first_fail_idx, 0);
    check("rst:dut_in", dut_in, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_sweep("and", 16'h8000, 16'h8000, 1'b0);
    run_sweep("parity", 16'h6996, 16'h6997, 1'b0);
    run_sweep("g10c9", 16'h10C9, 16'h10C9, 1'b0);
    run_sweep("g10c9_inv", 16'h10C9, 16'hEF36, 1'b0);

    // Abort while vector 5 is held: partial results kept, no done pulse.
    g = TT_W'($urandom); e = g ^ TT_W'($urandom);
    model(g, e, 5, cap, fc, ffi);
    d0 = done_pulses;
    gate_tt = g; expected_tt = e; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_vec("abort", 4'd5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort:busy", busy, 0);
    check("abort:dut_in", dut_in, 0);
    repeat (3) @(negedge clk);
    check("abort:no_done", done_pulses - d0, 0);
    check("abort:pass", pass, 0);
    check("abort:captured", captured_tt, cap);
    check("abort:fail_count", fail_count, fc);

    // Reset in the middle of vector 9, then a fresh sweep with start pokes.
    gate_tt = 16'hBEEF; expected_tt = 16'h1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_vec("midrst", 4'd9);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst:busy", busy, 0);
    check("midrst:dut_in", dut_in, 0);
    check("midrst:captured", captured_tt, 0);
    check("midrst:fail_count", fail_count, 0);
    check("midrst:first_fail", first_fail_idx, 0);
    check("midrst:pass_done", {pass, done}, 0);
    rst_n = 1'b1;
    g = TT_W'($urandom);
    run_sweep("after_rst", g, g ^ (TT_W'(1) << $urandom_range(15)), 1'b1);

    // Randomized sweeps with sparse and dense error masks.
    for (int k = 0; k < 6; k++) begin
      g = TT_W'($urandom);
      e = (k % 2 == 0) ? g ^ (TT_W'($urandom) & TT_W'($urandom)) : TT_W'($urandom);
      run_sweep($sformatf("rand%0d", k), g, e, k[0]);
    end

    // Zero-settle instance: two cycles per vector.
    @(negedge clk);
    gate0_tt = 16'h8000; expected0 = 16'h8000; start0 = 1'b1;
    @(posedge clk);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      start0 = 1'b0;
      if (done0) break;
      @(posedge clk);
      n++;
    end
    check("s0:cycles", n, CYC_S0);
    check("s0:pass", pass0, 1);
    check("s0:captured", captured0, 16'h8000);
    check("s0:fail_count", fail_count0, 0);

    // Simultaneous start and abort in IDLE: no sweep.
    @(negedge clk);
    start0 = 1'b1; abort0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; abort0 = 1'b0;
    check("s0:start_abort_busy", busy0, 0);
    @(negedge clk);
    check("s0:start_abort_idle", {busy0, done0}, 0);
    check("s0:start_abort_keep", pass0, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
